// File: rtl/uart.sv
// uart: byte-wide bus UART with TX FIFO, 8N1 serialiser, programmable baud
// divisor, single-byte RX buffer and a level interrupt.
// Optional receiver: define UART_RX_EN to build the RX path; without it rxd is
// ignored, DATA reads 8'h00 and the RX status flags are constant 0.
module uart #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       wren,
  input  logic       rden,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Bus decode
  logic wr_en, rd_en;
  assign wr_en = ce & wren;
  assign rd_en = ce & rden;

  // TX state and configuration registers
  state_t          tx_state_q, tx_state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     tx_cnt_q, tx_cnt_d;
  logic [15:0]     div_act_q, div_act_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     div_q, div_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic tx_full, tx_empty, tx_busy, tick, push, tx_pop;
  logic rx_valid, rx_ovr, rx_ferr;
  logic [7:0] rx_buf;

  assign tx_full  = (count_q == FULL_CNT);
  assign tx_empty = (count_q == '0);
  assign tx_busy  = (tx_state_q != ST_IDLE);
  // The bit period in force is latched, so a new divisor applies from the next tick.
  assign tick     = tx_busy && (tx_cnt_q == div_act_q);
  // Full is judged before any same-cycle pop, so a write while full is lost.
  assign push     = wr_en && (addr == 4'd0) && !tx_full;

  // TX FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_q <= ST_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  // TX FSM next state; a pop loads the shift register whenever a frame begins
  always_comb begin
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = ST_START;
          tx_pop     = 1'b1;
        end
      end
      ST_START: if (tick) tx_state_d = ST_DATA;
      ST_DATA:  if (tick && (bit_idx_q == 3'd7)) tx_state_d = ST_STOP;
      ST_STOP: begin
        if (tick) begin
          if (!tx_empty) begin
            tx_state_d = ST_START;
            tx_pop     = 1'b1;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // TX FSM output; idle level comes straight from the state so reset forces it high
  always_comb begin
    txd = 1'b1;
    case (tx_state_q)
      ST_IDLE:  txd = 1'b1;
      ST_START: txd = 1'b0;
      ST_DATA:  txd = shift_q[0];
      ST_STOP:  txd = 1'b1;
    endcase
  end

  // FIFO pointers, baud counter, shifter and register writes
  always_comb begin
    wr_ptr_d  = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = tx_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(tx_pop);
    tx_cnt_d  = (tx_pop || tick || !tx_busy) ? 16'd0 : tx_cnt_q + 16'd1;
    div_act_d = (tx_pop || tick) ? div_q : div_act_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    if (tx_pop) begin
      shift_d   = mem_q[rd_ptr_q];
      bit_idx_d = 3'd0;
    end else if ((tx_state_q == ST_DATA) && tick) begin
      shift_d   = {1'b0, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end
    div_d  = div_q;
    ctrl_d = ctrl_q;
    if (wr_en) begin
      case (addr)
        4'd2:    div_d[7:0]  = data_in;
        4'd3:    div_d[15:8] = data_in;
        4'd4:    ctrl_d      = data_in[1:0];
        default: ;
      endcase
    end
  end

  // TX datapath and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_cnt_q  <= 16'd0;
      div_act_q <= DIV_RESET;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      div_q     <= DIV_RESET;
      ctrl_q    <= 2'b00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_cnt_q  <= tx_cnt_d;
      div_act_q <= div_act_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef UART_RX_EN
  state_t      rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
  logic        rx_sample, rd_pop;
  logic [16:0] rx_half, rx_mid;

  assign rd_pop  = rd_en && (addr == 4'd0);
  assign rx_half = ({1'b0, div_q} + 17'd1) >> 1;
  assign rx_mid  = (rx_half == 17'd0) ? 17'd0 : rx_half - 17'd1;

  // RX sample strobe: mid start bit first, then one full bit period apart
  always_comb begin
    rx_sample = 1'b0;
    case (rx_state_q)
      ST_START:         rx_sample = ({1'b0, rx_cnt_q} == rx_mid);
      ST_DATA, ST_STOP: rx_sample = (rx_cnt_q == div_q);
      default:          rx_sample = 1'b0;
    endcase
  end

  // RX FSM state register plus input synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= ST_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

  // RX FSM next state; a high line at mid start bit is a false start
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      ST_IDLE:  if (!rx_s2_q && rx_prev_q) rx_state_d = ST_START;
      ST_START: if (rx_sample) rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_sample && (rx_bit_q == 3'd7)) rx_state_d = ST_STOP;
      ST_STOP:  if (rx_sample) rx_state_d = ST_IDLE;
    endcase
  end

  // RX datapath and flags; a pop in the same cycle as a load lets the load win
  always_comb begin
    rx_cnt_d   = ((rx_state_q == ST_IDLE) || rx_sample) ? 16'd0 : rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    if ((rx_state_q == ST_START) && rx_sample) rx_bit_d = 3'd0;
    if ((rx_state_q == ST_DATA) && rx_sample) begin
      rx_bit_d   = rx_bit_q + 3'd1;
      rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
    end
    if (rd_pop) rx_valid_d = 1'b0;
    if (wr_en && (addr == 4'd1)) begin
      if (data_in[4]) rx_ovr_d  = 1'b0;
      if (data_in[5]) rx_ferr_d = 1'b0;
    end
    if ((rx_state_q == ST_STOP) && rx_sample) begin
      if (!rx_s2_q) begin
        rx_ferr_d = 1'b1;
      end else if (rx_valid_q && !rd_pop) begin
        rx_ovr_d = 1'b1;
      end else begin
        rx_buf_d   = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  // RX datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_ovr   = rx_ovr_q;
  assign rx_ferr  = rx_ferr_q;
  assign rx_buf   = rx_buf_q;
`else
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_valid   = 1'b0;
  assign rx_ovr     = 1'b0;
  assign rx_ferr    = 1'b0;
  assign rx_buf     = 8'h00;
`endif

  // Read mux; quiet bus when not selected for read
  always_comb begin
    data_out = 8'h00;
    if (rd_en) begin
      case (addr)
        4'd0:    data_out = rx_buf;
        4'd1:    data_out = {2'b00, rx_ferr, rx_ovr, rx_valid, tx_busy, tx_empty, tx_full};
        4'd2:    data_out = div_q[7:0];
        4'd3:    data_out = div_q[15:8];
        4'd4:    data_out = {6'b000000, ctrl_q};
        default: data_out = 8'h00;
      endcase
    end
  end

  assign irq = (ctrl_q[0] & tx_empty & ~tx_busy) | (ctrl_q[1] & rx_valid);

endmodule

// File: tb/tb_uart.sv
// tb_uart: scoreboard bench for uart. Bus reads and serial TX frames are
// queued as expectations by the stimulus and checked by independent monitors.
module tb_uart;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       txd;
  logic       rxd = 1'b1;
  logic       irq;

  uart #(.FIFO_DEPTH(8), .DIV_RESET(16'd26)) dut (
    .clk(clk), .rst(rst), .ce(ce), .wren(wren), .rden(rden), .addr(addr),
    .data_in(data_in), .data_out(data_out), .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         chk_pins;
    logic       irq;
    logic       txd;
  } rd_exp_t;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } tx_exp_t;

  rd_exp_t rd_q[$];
  tx_exp_t tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm,
                    input bit cp = 1'b0, input logic ie = 1'b0, input logic te = 1'b1);
    rd_exp_t x;
    @(negedge clk);
    ce = 1'b1; rden = 1'b1; wren = 1'b0; addr = a; data_in = 8'h00;
    x.name = nm; x.data = e; x.chk_pins = cp; x.irq = ie; x.txd = te;
    rd_q.push_back(x);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; wren = 1'b1; rden = 1'b0; addr = a; data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b0; wren = 1'b0; rden = 1'b0;
    end
  endtask

  task automatic tx_push(input logic [7:0] d, input bit b2b);
    tx_exp_t x;
    x.data = d; x.b2b = b2b;
    tx_q.push_back(x);
  endtask

  // 8N1 frame on rxd, 4 clocks per bit (DIV=3), followed by 4 idle-high clocks
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [7:0] bb;
    bb = b;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0; rden = 1'b0;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = bb[i];
      repeat (4) @(negedge clk);
    end
    rxd = stop;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Read monitor: checks data_out (and optionally irq/txd) on every bus read
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (ce && rden) begin
        if (rd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_read: addr %0h data %02h, no read expected", addr, data_out);
        end else begin
          e = rd_q.pop_front();
          check(e.name, data_out, e.data);
          if (e.chk_pins) begin
            check({e.name, "_irq"}, irq, e.irq);
            check({e.name, "_txd"}, txd, e.txd);
          end
        end
      end
    end
  end

  // TX frame monitor: decodes 4-clock bits at mid-bit, checks byte, framing and spacing
  initial begin
    logic [7:0] b;
    logic       sb, pb;
    bit         ab;
    int         st, last_st;
    tx_exp_t    e;
    last_st = -1000;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        st = cyc; ab = 1'b0;
        repeat (2) @(negedge clk);
        sb = txd; if (rst) ab = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = txd; if (rst) ab = 1'b1;
        end
        repeat (4) @(negedge clk);
        pb = txd; if (rst) ab = 1'b1;
        @(negedge clk);
        if (!ab) begin
          if (tx_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL tx_unexpected_frame: got %02h, no frame expected", b);
          end else begin
            e = tx_q.pop_front();
            check("tx_byte", b, e.data);
            check("tx_start_bit", sb, 1'b0);
            check("tx_stop_bit", pb, 1'b1);
            if (e.b2b) check("tx_b2b_spacing", st - last_st, 40);
          end
        end
        last_st = st;
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic lv [10];
    logic te;
    logic [7:0] se;
    lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd(4'd1, 8'h02, "rst_status", 1'b1, 1'b0, 1'b1);
    rd(4'd2, 8'd26, "rst_divl");
    rd(4'd3, 8'h00, "rst_divh");
    rd(4'd4, 8'h00, "rst_ctrl");
    rd(4'd0, 8'h00, "rst_data");
    wr(4'd9, 8'hFF);
    rd(4'd9, 8'h00, "unmapped_after_wr");

    // Single frame 8'hA5 at DIV=3 with TXE_IE set
    wr(4'd2, 8'd3);
    wr(4'd3, 8'd0);
    wr(4'd4, 8'h01);
    rd(4'd2, 8'd3, "divl_written");
    rd(4'd1, 8'h02, "irq_idle_empty", 1'b1, 1'b1, 1'b1);
    tx_push(8'hA5, 1'b0);
    wr(4'd0, 8'hA5);
    for (int k = 0; k <= 41; k++) begin
      se = (k == 0) ? 8'h00 : (k <= 40) ? 8'h06 : 8'h02;
      te = (k == 0 || k == 41) ? 1'b1 : lv[(k - 1) / 4];
      rd(4'd1, se, $sformatf("a5_cyc%0d", k), 1'b1, (k == 41), te);
    end
    wr(4'd4, 8'h00);

    // FIFO fill behind a running frame; ninth write dropped
    tx_push(8'h10, 1'b0);
    wr(4'd0, 8'h10);
    for (int i = 0; i < 8; i++) begin
      tx_push(8'h20 + 8'(i), 1'b1);
      wr(4'd0, 8'h20 + 8'(i));
      if (i == 6) rd(4'd1, 8'h04, "fifo_seven");
    end
    rd(4'd1, 8'h05, "fifo_full");
    wr(4'd0, 8'h28);
    rd(4'd1, 8'h05, "full_after_drop");
    idle(400);
    rd(4'd1, 8'h02, "fifo_drained", 1'b1, 1'b0, 1'b1);

`ifdef UART_RX_EN
    // Receiver: valid/pop, overrun, framing error, glitch rejection
    wr(4'd4, 8'h02);
    send_rx(8'h3C, 1'b1);
    rd(4'd1, 8'h0A, "rx_valid", 1'b1, 1'b1, 1'b1);
    rd(4'd0, 8'h3C, "rx_data", 1'b1, 1'b1, 1'b1);
    rd(4'd1, 8'h02, "rx_popped", 1'b1, 1'b0, 1'b1);
    wr(4'd4, 8'h00);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(4'd1, 8'h1A, "rx_ovr");
    rd(4'd0, 8'h11, "rx_keep_first");
    rd(4'd1, 8'h12, "ovr_sticky");
    wr(4'd1, 8'h10);
    rd(4'd1, 8'h02, "ovr_cleared");
    send_rx(8'h55, 1'b0);
    rd(4'd1, 8'h22, "rx_ferr");
    wr(4'd1, 8'h20);
    rd(4'd1, 8'h02, "ferr_cleared");
    idle(1);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    idle(30);
    rd(4'd1, 8'h02, "glitch_ignored");
    rd(4'd0, 8'h11, "buf_after_glitch");
`else
    // Receiver absent: rxd has no effect, RXV_IE only reads back
    wr(4'd4, 8'h02);
    send_rx(8'h3C, 1'b1);
    rd(4'd1, 8'h02, "rx_disabled_status", 1'b1, 1'b0, 1'b1);
    rd(4'd0, 8'h00, "rx_disabled_data");
    rd(4'd4, 8'h02, "ctrl_rxv_readback", 1'b1, 1'b0, 1'b1);
    wr(4'd4, 8'h00);
`endif

    // Reset during the data phase of an all-zero frame with another byte queued
    wr(4'd0, 8'h00);
    wr(4'd0, 8'h00);
    idle(12);
    @(negedge clk);
    #1;
    check("txd_before_rst", txd, 1'b0);
    rst = 1'b1;
    #1;
    check("txd_async_rst", txd, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rd(4'd1, 8'h02, "status_after_rst", 1'b1, 1'b0, 1'b1);
    rd(4'd2, 8'd26, "divl_after_rst");
    idle(60);

    check("rd_queue_drained", rd_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
